// File: rtl/mux_arbiter_if.sv
// Bus between two requesters and the mux_arbiter.
// Requesters drive req/data. The arbiter returns acks, the mux select,
// the registered mux result and status.
interface mux_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_a;
  logic             ack_b;
  logic             sel;
  logic [WIDTH-1:0] chosen;
  logic             out_valid;
  logic             busy;
  logic [CNT_W-1:0] txn_count;

  // Requester side: raises requests and presents operands.
  modport master (
    output req_a, data_a, req_b, data_b,
    input  ack_a, ack_b, sel, chosen, out_valid, busy, txn_count
  );

  // Arbiter side: consumes requests and returns the transfer result.
  modport slave (
    input  req_a, data_a, req_b, data_b,
    output ack_a, ack_b, sel, chosen, out_valid, busy, txn_count
  );
endinterface

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving a shared, registered 2:1 mux.
// A grant lasts exactly one cycle. On the edge that leaves the grant, the
// mux result is captured and the owner is acked. So one transfer completes
// at most every two cycles.
module mux_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          resetn,
  mux_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  // Identity of a requester. It is used both for last_grant and for the
  // mux select, whose encoding is 0 = A and 1 = B.
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  state_t           state_q, state_d;
  owner_t           last_grant_q;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] chosen_q;
  logic             out_valid_q;
  logic             ack_a_q;
  logic             ack_b_q;
  logic [CNT_W-1:0] txn_count_q;
  logic             leaving_grant;

  // A grant never lasts more than one cycle, so every GRANT state is left
  // on the very next edge. A dropped request cannot revoke it.
  assign leaving_grant = (state_q != IDLE);

  // Next-state and select decode: round-robin only on a tie in IDLE.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          // The requester that was not served last wins the tie.
          if (last_grant_q == OWNER_A) begin
            state_d = GRANT_B;
            sel_d   = OWNER_B;
          end else begin
            state_d = GRANT_A;
            sel_d   = OWNER_A;
          end
        end else if (bus.req_a) begin
          state_d = GRANT_A;
          sel_d   = OWNER_A;
        end else if (bus.req_b) begin
          state_d = GRANT_B;
          sel_d   = OWNER_B;
        end
      end
      GRANT_A: state_d = IDLE;
      GRANT_B: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and mux select. The select holds its value through IDLE.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Transfer completion: capture the mux result, pulse valid and ack,
  // count the transfer, and remember who was served.
  // A reset during a grant clears everything before this edge is reached,
  // so an aborted transfer produces no ack and no count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= OWNER_B;
      chosen_q     <= '0;
      out_valid_q  <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      txn_count_q  <= '0;
    end else begin
      out_valid_q <= leaving_grant;
      ack_a_q     <= (state_q == GRANT_A);
      ack_b_q     <= (state_q == GRANT_B);
      if (leaving_grant) begin
        chosen_q     <= sel_q ? bus.data_b : bus.data_a;
        txn_count_q  <= txn_count_q + CNT_W'(1);
        last_grant_q <= (state_q == GRANT_B) ? OWNER_B : OWNER_A;
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.chosen    = chosen_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ack_a     = ack_a_q;
  assign bus.ack_b     = ack_b_q;
  assign bus.txn_count = txn_count_q;

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the data width of each requester and of the output.
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the width of the transfer counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_a  input  1  requester A transfer request, level, held until ack_a.
REQ-006 The block SHALL have port data_a  input  WIDTH  requester A operand, stable while req_a high.
REQ-007 The block SHALL have port req_b  input  1  requester B transfer request, level, held until ack_b.
REQ-008 The block SHALL have port data_b  input  WIDTH  requester B operand, stable while req_b high.
REQ-009 The block SHALL have port ack_a  output  1  one-cycle pulse; A's transfer is complete.
REQ-010 The block SHALL have port ack_b  output  1  one-cycle pulse; B's transfer is complete.
REQ-011 The block SHALL have port sel  output  1  mux select driven by the arbiter; 0 = A, 1 = B.
REQ-012 The block SHALL have port chosen  output  WIDTH  registered result of the shared 2:1 mux.
REQ-013 The block SHALL have port out_valid  output  1  one-cycle pulse; chosen was updated this cycle.
REQ-014 The block SHALL have port busy  output  1  high while a grant is outstanding.
REQ-015 The block SHALL have port txn_count  output  CNT_W  count of completed transfers.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, GRANT_A and GRANT_B.
REQ-017 In IDLE, on a rising edge:
- req_a only -> GRANT_A.
- req_b only -> GRANT_B.
- neither -> stay in IDLE.
REQ-018 In IDLE with req_a and req_b both high, the block SHALL grant the requester that was NOT last granted (round-robin).
REQ-019 The last_grant register SHALL update only on the edge that leaves a GRANT state.
REQ-020 In GRANT_A and GRANT_B, sel SHALL be 0 and 1 respectively, and busy SHALL be 1.
REQ-021 In IDLE, sel SHALL hold its last value and busy SHALL be 0.
REQ-022 On the edge leaving GRANT_x, the block SHALL perform all of the following in that same edge:
- chosen <= (sel ? data_b : data_a).
- out_valid = 1.
- ack_x = 1.
- txn_count increments by 1.
- next state = IDLE.
REQ-023 Latency SHALL be: request sampled at edge N -> chosen/out_valid/ack at edge N+1; maximum throughput is one transfer per 2 cycles.
REQ-024 out_valid, ack_a and ack_b SHALL be registered and high for exactly one cycle per transfer.
REQ-025 ack_a and ack_b SHALL never be high in the same cycle.
REQ-026 A grant SHALL NOT be revoked; if the granted req drops while in GRANT_x, the transfer still completes with the current data.
REQ-027 A req still high in the cycle after its ack SHALL be treated as a new request and arbitrated in IDLE.
REQ-028 chosen SHALL hold its value between transfers.
REQ-029 txn_count SHALL wrap from 2^CNT_W-1 to 0 without flagging.

Reset
REQ-030 While resetn = 0, the block SHALL immediately force all of the following, regardless of clk:
- state = IDLE.
- last_grant = B (so A wins the first tie).
- sel = 0, chosen = 0, out_valid = 0, ack_a = 0, ack_b = 0, busy = 0, txn_count = 0.
REQ-031 Reset asserted during GRANT_x SHALL abort the transfer with no ack, no out_valid and no count increment.
REQ-032 After resetn rises, arbitration SHALL resume at the first rising edge.

Verification
REQ-033 Single A: data_a=4'h2, req_a at edge 1 -> sel=0, busy=1; edge 2: chosen=4'h2, out_valid=1, ack_a=1, txn_count=1.
REQ-034 Tie after reset: data_a=4'h4, data_b=4'h7, both req held -> transfers alternate A,B,A,B; chosen sequence 4,7,4,7; ack_a and ack_b never coincide.
REQ-035 Back-to-back B only: data_b=4'hF, req_b held for 6 cycles -> 3 transfers, ack_b on every 2nd edge, txn_count=3.
REQ-036 Withdraw: req_b dropped in the GRANT_B cycle, data_b=4'h3 -> transfer completes: chosen=4'h3, ack_b=1.
REQ-037 Reset mid-transfer: resetn low during GRANT_A -> all outputs 0 immediately; no ack; next tie grants A.
REQ-038 Wrap: with CNT_W=2, 5 transfers -> txn_count sequence 1,2,3,0,1.
